// File: rtl/bp_lce_resp_arbiter_if.sv
// Handshake bundle between the response sources, the LCE response arbiter and
// the downstream lce_resp consumer. master = arbiter side, slave = source/sink side.
interface bp_lce_resp_arbiter_if #(
  parameter int num_src_p    = 2,
  parameter int resp_width_p = 64
);
  localparam int id_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;

  logic [num_src_p*resp_width_p-1:0] src_resp_i;
  logic [num_src_p-1:0]              src_v_i;
  logic [num_src_p-1:0]              src_yumi_o;
  logic [resp_width_p-1:0]           lce_resp_o;
  logic                              lce_resp_v_o;
  logic                              lce_resp_ready_i;
  logic [id_width_lp-1:0]            src_id_o;

  modport master (
    input  src_resp_i, src_v_i, lce_resp_ready_i,
    output src_yumi_o, lce_resp_o, lce_resp_v_o, src_id_o
  );

  modport slave (
    output src_resp_i, src_v_i, lce_resp_ready_i,
    input  src_yumi_o, lce_resp_o, lce_resp_v_o, src_id_o
  );
endinterface

// File: rtl/bp_lce_resp_arbiter.sv
// N-source LCE->CCE response arbiter with a one-entry registered output stage.
// Optional macro BP_LCE_RESP_ARB_STARVE_EN adds a starvation guard to fixed-priority mode.
module bp_lce_resp_arbiter #(
  parameter int num_src_p      = 2,
  parameter int resp_width_p   = 64,
  parameter int rr_mode_p      = 1,
  parameter int starve_limit_p = 15
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bp_lce_resp_arbiter_if.master bus
);
  localparam int id_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;
`ifdef BP_LCE_RESP_ARB_STARVE_EN
  localparam bit starve_en_lp = (rr_mode_p == 0);
`else
  localparam bit starve_en_lp = 1'b0;
`endif

  logic [num_src_p-1:0]    src_v;
  logic [num_src_p-1:0]    starved;
  logic [num_src_p-1:0]    yumi;
  logic [id_width_lp-1:0]  ptr_reg;
  logic [id_width_lp-1:0]  winner;
  logic                    grant_v;
  logic                    load;
  logic [resp_width_p-1:0] winner_data;

  logic                    v_reg;
  logic [resp_width_p-1:0] data_reg;
  logic [id_width_lp-1:0]  id_reg;

  assign src_v = bus.src_v_i;

  // Loops run backwards through the search order so the last hit is the winner.
  always_comb begin : arbitrate
    int idx;
    idx     = 0;
    grant_v = 1'b0;
    winner  = '0;
    if (|starved) begin
      grant_v = 1'b1;
      for (int k = num_src_p - 1; k >= 0; k--) begin
        if (starved[k[id_width_lp-1:0]]) winner = k[id_width_lp-1:0];
      end
    end else if (rr_mode_p != 0) begin
      for (int off = num_src_p; off >= 1; off--) begin
        idx = int'(ptr_reg) + off;
        if (idx >= num_src_p) idx = idx - num_src_p;
        if (src_v[idx[id_width_lp-1:0]]) begin
          grant_v = 1'b1;
          winner  = idx[id_width_lp-1:0];
        end
      end
    end else begin
      for (int k = num_src_p - 1; k >= 0; k--) begin
        if (src_v[k[id_width_lp-1:0]]) begin
          grant_v = 1'b1;
          winner  = k[id_width_lp-1:0];
        end
      end
    end
  end

  assign load        = grant_v & (~v_reg | bus.lce_resp_ready_i);
  assign winner_data = bus.src_resp_i[winner*resp_width_p +: resp_width_p];

  always_comb begin
    yumi = '0;
    if (load && reset_n_i) yumi[winner] = 1'b1;
  end

  generate
    if (rr_mode_p != 0) begin : g_rr_ptr
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)  ptr_reg <= id_width_lp'(num_src_p - 1);
        else if (load)   ptr_reg <= winner;
      end
    end else begin : g_no_ptr
      assign ptr_reg = '0;
    end

    if (starve_en_lp) begin : g_starve
      localparam int cnt_width_lp = (starve_limit_p > 0) ? $clog2(starve_limit_p + 1) : 1;
      for (genvar gi = 0; gi < num_src_p; gi++) begin : g_cnt
        logic [cnt_width_lp-1:0] cnt_reg;
        // Counts arbitrations lost while continuously valid; saturates at all-ones.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
          if (!reset_n_i)                               cnt_reg <= '0;
          else if (!src_v[gi] || yumi[gi])              cnt_reg <= '0;
          else if (load && (cnt_reg != {cnt_width_lp{1'b1}})) cnt_reg <= cnt_reg + 1'b1;
        end
        assign starved[gi] = src_v[gi] && (cnt_reg >= cnt_width_lp'(starve_limit_p));
      end
    end else begin : g_no_starve
      assign starved = '0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_reg    <= 1'b0;
      data_reg <= '0;
      id_reg   <= '0;
    end else if (load) begin
      v_reg    <= 1'b1;
      data_reg <= winner_data;
      id_reg   <= winner;
    end else if (v_reg && bus.lce_resp_ready_i) begin
      v_reg    <= 1'b0;
    end
  end

  assign bus.src_yumi_o   = yumi;
  assign bus.lce_resp_o   = data_reg;
  assign bus.lce_resp_v_o = v_reg;
  assign bus.src_id_o     = id_reg;

`ifndef SYNTHESIS
  a_yumi_onehot0: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(yumi));
  a_hold_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (v_reg && !bus.lce_resp_ready_i) |=> ($stable(data_reg) && $stable(id_reg)));
`endif
endmodule

// File: tb/tb_bp_lce_resp_arbiter.sv
// Bench for bp_lce_resp_arbiter: three configurations (4-src RR, 2-src fixed, 1-src)
// checked every cycle against a rule-level model plus hand-computed expectations.
module tb_bp_lce_resp_arbiter;
  localparam int W = 16;
  localparam int NS  [3] = '{4, 2, 1};
  localparam bit RR  [3] = '{1'b1, 1'b0, 1'b1};
  localparam int LIM [3] = '{15, 3, 15};
`ifdef BP_LCE_RESP_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
  localparam int EXP_G2 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
`else
  localparam bit STARVE = 1'b0;
  localparam int EXP_G2 [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
  localparam int EXP_G4 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bp_lce_resp_arbiter_if #(.num_src_p(4), .resp_width_p(W)) bus4 ();
  bp_lce_resp_arbiter_if #(.num_src_p(2), .resp_width_p(W)) bus2 ();
  bp_lce_resp_arbiter_if #(.num_src_p(1), .resp_width_p(W)) bus1 ();

  bp_lce_resp_arbiter #(.num_src_p(4), .resp_width_p(W), .rr_mode_p(1), .starve_limit_p(15))
    u_rr4 (.clk_i(clk), .reset_n_i(rst_n), .bus(bus4.master));
  bp_lce_resp_arbiter #(.num_src_p(2), .resp_width_p(W), .rr_mode_p(0), .starve_limit_p(3))
    u_fix2 (.clk_i(clk), .reset_n_i(rst_n), .bus(bus2.master));
  bp_lce_resp_arbiter #(.num_src_p(1), .resp_width_p(W), .rr_mode_p(1), .starve_limit_p(15))
    u_one1 (.clk_i(clk), .reset_n_i(rst_n), .bus(bus1.master));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what each output register must hold after the most recent edge.
  bit             m_v    [3] = '{0, 0, 0};
  logic [W-1:0]   m_data [3] = '{'0, '0, '0};
  int             m_id   [3] = '{0, 0, 0};
  int             m_ptr  [3] = '{3, 1, 0};
  int             m_cnt  [3][4];

  function automatic int pick(input int d, input logic [3:0] v);
    int n;
    n = NS[d];
    if (!RR[d] && STARVE)
      for (int k = 0; k < n; k++)
        if (v[k] && m_cnt[d][k] >= LIM[d]) return k;
    if (RR[d]) begin
      for (int s = 1; s <= n; s++)
        if (v[(m_ptr[d] + s) % n]) return (m_ptr[d] + s) % n;
    end else begin
      for (int k = 0; k < n; k++)
        if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input logic [3:0] v, input logic [63:0] resp,
                            input logic rdy, input logic [3:0] a_yumi, input logic a_v,
                            input logic [W-1:0] a_data, input int a_id);
    logic [3:0] e_yumi;
    int         win;
    bit         load;
    string      tag;
    tag = $sformatf("cfg%0d", d);
    if (!rst_n) begin
      m_v[d] = 0; m_data[d] = '0; m_id[d] = 0; m_ptr[d] = NS[d] - 1;
      for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
    end
    win    = rst_n ? pick(d, v) : -1;
    load   = (win >= 0) && (!m_v[d] || rdy);
    e_yumi = load ? (4'd1 << win) : 4'd0;
    chk({tag, "_yumi"}, a_yumi, e_yumi);
    chk({tag, "_v"},    a_v,    m_v[d]);
    chk({tag, "_data"}, a_data, m_data[d]);
    chk({tag, "_id"},   a_id,   m_id[d]);
    if (!rst_n) return;
    for (int k = 0; k < NS[d]; k++) begin
      if (!v[k] || (load && win == k)) m_cnt[d][k] = 0;
      else if (load && m_cnt[d][k] < LIM[d]) m_cnt[d][k]++;
    end
    if (load) begin
      m_v[d] = 1; m_data[d] = resp[win*W +: W]; m_id[d] = win; m_ptr[d] = win;
    end else if (m_v[d] && rdy) begin
      m_v[d] = 0;
    end
  endtask

  logic [3:0] y4_s = '0;
  logic [1:0] y2_s = '0;
  logic       y1_s = 1'b0;
  int         g4 [$];
  int         g2 [$];

  // Compare process: outputs are stable here, half a cycle from either edge.
  initial forever begin
    @(negedge clk);
    model_step(0, bus4.src_v_i, bus4.src_resp_i, bus4.lce_resp_ready_i,
               bus4.src_yumi_o, bus4.lce_resp_v_o, bus4.lce_resp_o, int'(bus4.src_id_o));
    model_step(1, {2'b0, bus2.src_v_i}, {32'b0, bus2.src_resp_i}, bus2.lce_resp_ready_i,
               {2'b0, bus2.src_yumi_o}, bus2.lce_resp_v_o, bus2.lce_resp_o, int'(bus2.src_id_o));
    model_step(2, {3'b0, bus1.src_v_i}, {48'b0, bus1.src_resp_i}, bus1.lce_resp_ready_i,
               {3'b0, bus1.src_yumi_o}, bus1.lce_resp_v_o, bus1.lce_resp_o, int'(bus1.src_id_o));
    y4_s = bus4.src_yumi_o;
    y2_s = bus2.src_yumi_o;
    y1_s = bus1.src_yumi_o;
    if (rst_n && bus4.src_yumi_o != 0) g4.push_back($clog2(bus4.src_yumi_o));
    if (rst_n && bus2.src_yumi_o != 0) g2.push_back($clog2(bus2.src_yumi_o));
  end

  // Sources: each presents a new payload only after it has been consumed.
  logic [7:0] seq4 [4] = '{8'h00, 8'h10, 8'h20, 8'h30};
  logic [7:0] seq2 [2] = '{8'h40, 8'h50};
  logic [7:0] seq1     = 8'h60;

  task automatic drive_payloads();
    for (int k = 0; k < 4; k++) bus4.src_resp_i[k*W +: W] = {4'h4, 4'(k), seq4[k]};
    for (int k = 0; k < 2; k++) bus2.src_resp_i[k*W +: W] = {4'h2, 4'(k), seq2[k]};
    bus1.src_resp_i = {4'h1, 4'h0, seq1};
  endtask

  initial begin
    drive_payloads();
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) if (y4_s[k]) seq4[k] = seq4[k] + 8'd1;
      for (int k = 0; k < 2; k++) if (y2_s[k]) seq2[k] = seq2[k] + 8'd1;
      if (y1_s) seq1 = seq1 + 8'd1;
      drive_payloads();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v4, input logic [1:0] v2, input logic v1, input logic r);
    bus4.src_v_i = v4; bus2.src_v_i = v2; bus1.src_v_i = v1;
    bus4.lce_resp_ready_i = r; bus2.lce_resp_ready_i = r; bus1.lce_resp_ready_i = r;
  endtask

  typedef struct packed { logic [3:0] v4; logic [1:0] v2; logic v1; logic r; } vec_t;
  vec_t vecs [12] = '{
    '{4'b1010, 2'b10, 1'b1, 1'b1}, '{4'b0100, 2'b01, 1'b0, 1'b1},
    '{4'b0000, 2'b00, 1'b0, 1'b1}, '{4'b0000, 2'b00, 1'b0, 1'b1},
    '{4'b1001, 2'b11, 1'b1, 1'b0}, '{4'b1001, 2'b11, 1'b1, 1'b1},
    '{4'b0110, 2'b10, 1'b1, 1'b1}, '{4'b1111, 2'b11, 1'b1, 1'b0},
    '{4'b1111, 2'b11, 1'b1, 1'b1}, '{4'b0001, 2'b01, 1'b0, 1'b1},
    '{4'b1000, 2'b10, 1'b1, 1'b1}, '{4'b0000, 2'b00, 1'b0, 1'b1}
  };

  initial begin
    rst_n = 1'b1;
    drive(4'hf, 2'b11, 1'b1, 1'b1);
    #1 rst_n = 1'b0;

    // Reset held with every source valid.
    repeat (3) step();
    #1;
    chk("rst_yumi4", bus4.src_yumi_o, 0);
    chk("rst_v4", bus4.lce_resp_v_o, 0);
    chk("rst_yumi2", bus2.src_yumi_o, 0);
    chk("rst_yumi1", bus1.src_yumi_o, 0);
    g4.delete();
    g2.delete();

    step();
    rst_n = 1'b1;
    #1;
    chk("first_yumi4", bus4.src_yumi_o, 4'b0001);
    chk("first_yumi2", bus2.src_yumi_o, 2'b01);
    chk("first_yumi1", bus1.src_yumi_o, 1'b1);
    step();
    #1;
    chk("first_v4", bus4.lce_resp_v_o, 1);
    chk("first_id4", bus4.src_id_o, 0);

    // Fairness / fixed-priority order with ready held high.
    repeat (10) step();
    chk("grants_seen4", g4.size() >= 8, 1);
    chk("grants_seen2", g2.size() >= 8, 1);
    for (int i = 0; i < 8 && i < g4.size(); i++) chk($sformatf("rr_order4[%0d]", i), g4[i], EXP_G4[i]);
    for (int i = 0; i < 8 && i < g2.size(); i++) chk($sformatf("fixed_order2[%0d]", i), g2[i], EXP_G2[i]);

    // Backpressure: hold for five cycles, then drain and reload together.
    drive(4'hf, 2'b11, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_yumi4", bus4.src_yumi_o, 0);
      chk("bp_v4", bus4.lce_resp_v_o, 1);
      step();
    end
    drive(4'hf, 2'b11, 1'b1, 1'b1);
    #1;
    chk("bp_release_load4", |bus4.src_yumi_o, 1);

    foreach (vecs[i]) begin
      step();
      drive(vecs[i].v4, vecs[i].v2, vecs[i].v1, vecs[i].r);
    end
    for (int i = 0; i < 24; i++) begin
      step();
      drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
    end

    // Mid-operation reset while the output is stalled.
    step();
    drive(4'hf, 2'b11, 1'b1, 1'b0);
    step();
    step();
    #1;
    chk("pre_rst_v4", bus4.lce_resp_v_o, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_v4", bus4.lce_resp_v_o, 0);
    chk("midrst_yumi4", bus4.src_yumi_o, 0);
    step();
    step();
    rst_n = 1'b1;
    drive(4'b0100, 2'b11, 1'b1, 1'b1);
    #1;
    chk("post_rst_yumi4", bus4.src_yumi_o, 4'b0100);
    step();
    drive(4'b1001, 2'b11, 1'b1, 1'b1);
    #1;
    chk("ptr_wrap_yumi4", bus4.src_yumi_o, 4'b1000);
    chk("ptr_wrap_id4", bus4.src_id_o, 2);
    step();
    #1;
    chk("ptr_wrap_next_id4", bus4.src_id_o, 3);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
